// File: rtl/sd_result_logger.sv
`default_nettype none
// ============================================================================
// Module   : sd_result_logger
// Purpose  : Captures UUT result bytes into a ring FIFO and streams them out
//            as 512-byte SD blocks through the sdspihost write port. Capture
//            continues while a block is being written.
// Ports    : clk, rst (async, active-low)
//            enable                 - level; low forces IDLE and flushes FIFO
//            in_valid, in_data      - result byte capture strobe
//            spi_busy, spi_err      - sdspihost handshake / error
//            spi_w_block            - pulse: open block at spi_block_addr
//            spi_w_byte, spi_data_in- pulse + held data byte
//            spi_block_addr         - current block address
//            fifo_level             - bytes held in the FIFO
//            blocks_written         - completed blocks
//            overflow, done, error  - status (overflow/error are sticky)
// Options  : LOGGER_SEQ_HEADER_EN - prefix each block with blocks_written as
//            a 32-bit big-endian value; only BLOCK_BYTES-4 bytes come from
//            the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sd_result_logger #(
    parameter int          FIFO_DEPTH  = 1024,
    parameter int          BLOCK_BYTES = 512,
    parameter logic [31:0] START_BLOCK = 32'h100,
    parameter int          NUM_BLOCKS  = 16,
    parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        spi_busy,
    input  logic        spi_err,
    output logic        spi_w_block,
    output logic        spi_w_byte,
    output logic [7:0]  spi_data_in,
    output logic [31:0] spi_block_addr,
    output logic [10:0] fifo_level,
    output logic [15:0] blocks_written,
    output logic        overflow,
    output logic        done,
    output logic        error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BLOCK_BYTES);
`ifdef LOGGER_SEQ_HEADER_EN
    localparam int               HDR_BYTES = 4;
    localparam logic [BW-1:0]    c_HDR     = BW'(HDR_BYTES);
`else
    localparam int               HDR_BYTES = 0;
`endif
    localparam logic [10:0]      c_DEPTH     = 11'(FIFO_DEPTH);
    localparam logic [10:0]      c_FILL      = 11'(BLOCK_BYTES - HDR_BYTES);
    localparam logic [BW-1:0]    c_LAST_BYTE = BW'(BLOCK_BYTES - 1);
    localparam logic [15:0]      c_NUM       = 16'(NUM_BLOCKS);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_FILL, S_OPEN, S_OPEN_ACK, S_WAIT_RDY,
        S_SEND, S_BYTE_ACK, S_BLK_END, S_DONE, S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [10:0]     r_level;
    logic            r_overflow;

    logic [15:0]     r_tmo;
    logic [BW-1:0]   r_byte_cnt;
    logic [7:0]      r_data;
    logic [31:0]     r_addr;
    logic [15:0]     r_blocks;
    logic            r_done;
    logic            r_error;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_fifo_rd;
    logic            w_from_fifo;
    logic [7:0]      w_tx_byte;
    logic            w_timed;
    logic            w_tmo_hit;

    // ---------------------------------------------------------------- FIFO
    // Capture is ignored while disabled so the flush holds for the whole
    // low period, not just the falling edge.
    assign w_full    = (r_level == c_DEPTH);
    assign w_push    = enable && in_valid && !w_full;
    assign w_fifo_rd = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (!enable) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 11'd1;
                2'b01:   r_level <= r_level - 11'd1;
                default: r_level <= r_level;
            endcase
            if (in_valid && w_full) r_overflow <= 1'b1;
        end
    end

    // --------------------------------------------------- outgoing byte mux
    always_comb begin
        w_from_fifo = 1'b1;
        w_tx_byte   = w_fifo_rd;
`ifdef LOGGER_SEQ_HEADER_EN
        if (r_byte_cnt < c_HDR) begin
            w_from_fifo = 1'b0;
            case (r_byte_cnt[1:0])
                2'd2:    w_tx_byte = r_blocks[15:8];
                2'd3:    w_tx_byte = r_blocks[7:0];
                default: w_tx_byte = 8'h00;
            endcase
        end
`endif
    end

    // ------------------------------------------------------------- control
    assign w_timed   = (r_state == S_OPEN_ACK) || (r_state == S_WAIT_RDY) ||
                       (r_state == S_BYTE_ACK) || (r_state == S_BLK_END);
    assign w_tmo_hit = (r_tmo == ACK_TIMEOUT - 16'd1);

    // Priority: enable low, then spi_err, then the state's own handshake edge,
    // then the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else if (spi_err && (r_state != S_IDLE)) begin
            w_state_nxt = S_ERROR;
        end else begin
            case (r_state)
                S_IDLE:      w_state_nxt = S_WAIT_FILL;
                S_WAIT_FILL: if ((r_level >= c_FILL) && !spi_busy) w_state_nxt = S_OPEN;
                S_OPEN:      w_state_nxt = S_OPEN_ACK;
                S_OPEN_ACK: begin
                    if (spi_busy)       w_state_nxt = S_WAIT_RDY;
                    else if (w_tmo_hit) w_state_nxt = S_ERROR;
                end
                S_WAIT_RDY: begin
                    if (!spi_busy) begin
                        w_state_nxt = S_SEND;
                        w_pop       = w_from_fifo;
                    end else if (w_tmo_hit) begin
                        w_state_nxt = S_ERROR;
                    end
                end
                S_SEND:      w_state_nxt = S_BYTE_ACK;
                S_BYTE_ACK: begin
                    if (spi_busy)       w_state_nxt = (r_byte_cnt == c_LAST_BYTE) ? S_BLK_END : S_WAIT_RDY;
                    else if (w_tmo_hit) w_state_nxt = S_ERROR;
                end
                S_BLK_END: begin
                    if (!spi_busy)      w_state_nxt = (r_blocks + 16'd1 == c_NUM) ? S_DONE : S_WAIT_FILL;
                    else if (w_tmo_hit) w_state_nxt = S_ERROR;
                end
                S_DONE:      w_state_nxt = S_DONE;
                S_ERROR:     w_state_nxt = S_ERROR;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tmo      <= '0;
            r_byte_cnt <= '0;
            r_data     <= '0;
            r_addr     <= START_BLOCK;
            r_blocks   <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (!w_timed || (w_state_nxt != r_state)) r_tmo <= '0;
            else                                     r_tmo <= r_tmo + 16'd1;

            // A fresh run restarts the block sequence; error stays until reset.
            if ((r_state == S_IDLE) && (w_state_nxt == S_WAIT_FILL)) begin
                r_addr   <= START_BLOCK;
                r_blocks <= '0;
                r_done   <= 1'b0;
            end

            if (r_state == S_OPEN) r_byte_cnt <= '0;

            if ((r_state == S_WAIT_RDY) && (w_state_nxt == S_SEND)) r_data <= w_tx_byte;

            if ((r_state == S_BYTE_ACK) &&
                ((w_state_nxt == S_WAIT_RDY) || (w_state_nxt == S_BLK_END))) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if ((r_state == S_BLK_END) &&
                ((w_state_nxt == S_WAIT_FILL) || (w_state_nxt == S_DONE))) begin
                r_blocks <= r_blocks + 16'd1;
                r_addr   <= r_addr + 32'd1;
            end

            if (w_state_nxt == S_DONE)  r_done  <= 1'b1;
            if (w_state_nxt == S_ERROR) r_error <= 1'b1;
        end
    end

    // --------------------------------------------------------------- outputs
    assign spi_w_block    = (r_state == S_OPEN);
    assign spi_w_byte     = (r_state == S_SEND);
    assign spi_data_in    = r_data;
    assign spi_block_addr = r_addr;
    assign fifo_level     = r_level;
    assign blocks_written = r_blocks;
    assign overflow       = r_overflow;
    assign done           = r_done;
    assign error          = r_error;

endmodule
`default_nettype wire
